jtbubl_sndcomm: RTL and testbench
=================================

Name: jtbubl_sndcomm

Overview:
Mailbox between the main CPU's sound window (0xFA00-0xFA7F) and the sound CPU's latch window. It replaces the bare snd_latch/snd_rst registers with:
- a command latch and a reply latch, each with a pending flag;
- a sticky overrun flag;
- sound-CPU NMI generation gated by a sound-side enable;
- a sound-CPU reset with a guaranteed minimum pulse length.
It sits between the main CPU address decoder (sound_cs) and the sound CPU.

Parameters:
RST_LEN, 16, minimum snd_rst high time in cen ticks after the release request.

Ports:
clk24 input 1 system clock
rst_n input 1 asynchronous active-low reset
cen input 1 clock enable used only by the reset-length counter
main_cs input 1 main CPU in sound window (level, held for the whole access)
main_wrn input 1 main write strobe, active low
main_addr input 2 main register select
main_din input 8 main write data
main_dout output 8 main read data
snd_cs input 1 sound CPU in latch window (level)
snd_wrn input 1 sound write strobe, active low
snd_addr input 1 sound register select
snd_din input 8 sound write data
snd_dout output 8 sound read data
snd_nmi_n output 1 NMI to sound CPU, active low
snd_rst output 1 sound CPU reset, active high

Behaviour:
- One clock (clk24); rst_n asynchronous active-low. All state is registered on clk24.
- Access events:
  - Write event = rising edge of (cs & !wrn), detected against a registered copy. One event per bus access, however long cs is held.
  - Read event = falling edge of (cs & wrn), i.e. the end of a read. Flags clear after the CPU has sampled the data.
- Main map:
  - Read addr0: reply latch. Read event clears reply_pend.
  - Read addr1: status {5'b0, ovr, reply_pend, cmd_pend}. Read event clears ovr.
  - Reads of addr2/3 return 8'hFF.
  - Write addr0: cmd <= main_din; cmd_pend <= 1. If cmd_pend was already 1, ovr <= 1.
  - Write addr3: rst_req <= main_din[0].
  - Writes to addr1/2 are ignored.
- Sound map:
  - Read 0: cmd latch. Read event clears cmd_pend.
  - Read 1: status {6'b0, reply_pend, cmd_pend}.
  - Write 0: reply <= snd_din; reply_pend <= 1.
  - Write 1: din[0]=1 clears nmi_en. Otherwise din[1]=1 sets nmi_en. The disable bit wins.
- NMI: snd_nmi_n = ~(cmd_pend & nmi_en & !snd_rst). It is registered, so it updates one clk24 after the flag change. It stays low until the command is read or NMI is disabled.
- Reset:
  - rst_req=1 forces snd_rst=1 immediately (next clk24).
  - On rst_req 1->0, a counter loads RST_LEN and decrements on cen. snd_rst falls on the clk24 after the counter reaches 0.
  - A new rst_req=1 during the countdown holds snd_rst high and reloads the counter on the next release.
  - While snd_rst=1: nmi_en is held at 0 and the sound-side flags are frozen. Main writes still update cmd and cmd_pend, so a command written during reset is delivered after release.
- Simultaneous events: a set and a clear of the same pending flag in the same clk24 leaves the flag at 1 (set wins). ovr set and clear in the same cycle leaves ovr at 1.
- Read data paths are combinational muxes of the registers. No wait states.
- Reset values:
  - cmd=0, reply=0, cmd_pend=0, reply_pend=0, ovr=0, nmi_en=0.
  - rst_req=1, snd_rst=1, counter=RST_LEN, snd_nmi_n=1.
  - Edge-detect registers reset to 0.
  - main_dout/snd_dout follow the mux (8'hFF when cs is low).
- Asserting rst_n mid-access discards any pending edge. The first access after release is only detected from a clean low→high transition.

Test Plan:
1. rst_n low→high, main writes addr3=0x00, 20 cen ticks → snd_rst falls after exactly RST_LEN=16 cen ticks; snd_nmi_n stays 1.
2. Sound writes addr1=0x02; main writes 0x5A to addr0 with cs held 8 clk24 → cmd_pend=1 once; snd_nmi_n low one clk24 after the write edge; sound read addr0 returns 0x5A; after the read ends, cmd_pend=0 and snd_nmi_n=1.
3. Two main writes 0x11 then 0x22 without a sound read → main status read returns 0x05; sound sees 0x22; a second main status read returns 0x01.
4. Sound writes reply 0xC3 → main status 0x02; main read addr0 = 0xC3; then status 0x00.
5. Sound read-end of cmd coincides with a main cmd write on the same clk24 → cmd_pend remains 1 and the new value is latched.
6. During the reset countdown (rst_req back to 0), main writes addr3=1 then addr3=0 → snd_rst never drops; the countdown restarts from 16; nmi_en=0 after release.

Source files
------------

// File: rtl/jtbubl_sndcomm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtbubl_sndcomm : main/sound CPU mailbox with NMI and timed sound reset   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module jtbubl_sndcomm #(
  parameter int RST_LEN = 16
) (
  input  logic       clk24,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       main_cs,
  input  logic       main_wrn,
  input  logic [1:0] main_addr,
  input  logic [7:0] main_din,
  output logic [7:0] main_dout,
  input  logic       snd_cs,
  input  logic       snd_wrn,
  input  logic       snd_addr,
  input  logic [7:0] snd_din,
  output logic [7:0] snd_dout,
  output logic       snd_nmi_n,
  output logic       snd_rst
);

  localparam int CW = $clog2(RST_LEN + 1);

  logic [7:0]    cmd, reply;
  logic          cmd_pend, reply_pend, ovr, nmi_en, rst_req;
  logic [CW-1:0] cnt;

  logic       main_wr_l, main_rd_l, main_arm;
  logic [1:0] main_rd_addr;
  logic       snd_wr_l, snd_rd_l, snd_arm;
  logic       snd_rd_addr;

  logic main_wr, main_rd, snd_wr, snd_rd;
  logic main_wr_ev, main_rd_ev, snd_wr_ev, snd_rd_ev;
  logic cmd_set, cmd_clr, reply_set, reply_clr, ovr_set, ovr_clr;

  always_comb begin
    main_wr    = main_cs & ~main_wrn;
    main_rd    = main_cs &  main_wrn;
    snd_wr     = snd_cs  & ~snd_wrn;
    snd_rd     = snd_cs  &  snd_wrn;
    // arm stays low until a bus is seen idle, so an access straddling rst_n is ignored
    main_wr_ev = main_wr & ~main_wr_l & main_arm;
    main_rd_ev = ~main_rd & main_rd_l & main_arm;
    snd_wr_ev  = snd_wr & ~snd_wr_l & snd_arm & ~snd_rst;
    snd_rd_ev  = ~snd_rd & snd_rd_l & snd_arm & ~snd_rst;
    cmd_set    = main_wr_ev & (main_addr == 2'd0);
    cmd_clr    = snd_rd_ev & (snd_rd_addr == 1'b0);
    reply_set  = snd_wr_ev & (snd_addr == 1'b0);
    reply_clr  = main_rd_ev & (main_rd_addr == 2'd0);
    ovr_set    = cmd_set & cmd_pend;
    ovr_clr    = main_rd_ev & (main_rd_addr == 2'd1);
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      main_wr_l    <= 1'b0;
      main_rd_l    <= 1'b0;
      main_arm     <= 1'b0;
      main_rd_addr <= 2'd0;
      snd_wr_l     <= 1'b0;
      snd_rd_l     <= 1'b0;
      snd_arm      <= 1'b0;
      snd_rd_addr  <= 1'b0;
    end else begin
      main_wr_l <= main_wr;
      main_rd_l <= main_rd;
      main_arm  <= main_arm | ~main_cs;
      snd_wr_l  <= snd_wr;
      snd_rd_l  <= snd_rd;
      snd_arm   <= snd_arm | ~snd_cs;
      if (main_rd) main_rd_addr <= main_addr;
      if (snd_rd)  snd_rd_addr  <= snd_addr;
    end
  end

  // Set beats clear on every flag when both land in the same cycle
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      cmd        <= 8'd0;
      reply      <= 8'd0;
      cmd_pend   <= 1'b0;
      reply_pend <= 1'b0;
      ovr        <= 1'b0;
      nmi_en     <= 1'b0;
      rst_req    <= 1'b1;
    end else begin
      if (cmd_set) cmd <= main_din;
      if (reply_set) reply <= snd_din;
      if (main_wr_ev && main_addr == 2'd3) rst_req <= main_din[0];
      cmd_pend   <= cmd_set   | (cmd_pend   & ~cmd_clr);
      reply_pend <= reply_set | (reply_pend & ~reply_clr);
      ovr        <= ovr_set   | (ovr        & ~ovr_clr);
      if (snd_rst) begin
        nmi_en <= 1'b0;
      end else if (snd_wr_ev && snd_addr == 1'b1) begin
        if (snd_din[0])      nmi_en <= 1'b0;
        else if (snd_din[1]) nmi_en <= 1'b1;
      end
    end
  end

  // Counter is held loaded while the request is active, so each release restarts it
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      snd_rst   <= 1'b1;
      cnt       <= CW'(RST_LEN);
      snd_nmi_n <= 1'b1;
    end else begin
      if (rst_req) begin
        snd_rst <= 1'b1;
        cnt     <= CW'(RST_LEN);
      end else if (snd_rst) begin
        if (cnt == '0) snd_rst <= 1'b0;
        else if (cen)  cnt     <= cnt - 1'b1;
      end
      snd_nmi_n <= ~(cmd_pend & nmi_en & ~snd_rst);
    end
  end

  always_comb begin
    main_dout = 8'hFF;
    if (main_cs) begin
      case (main_addr)
        2'd0:    main_dout = reply;
        2'd1:    main_dout = {5'b0, ovr, reply_pend, cmd_pend};
        default: main_dout = 8'hFF;
      endcase
    end
    snd_dout = 8'hFF;
    if (snd_cs) snd_dout = snd_addr ? {6'b0, reply_pend, cmd_pend} : cmd;
  end

endmodule
`default_nettype wire

// File: tb/tb_jtbubl_sndcomm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jtbubl_sndcomm : directed self-checking bench for jtbubl_sndcomm      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_jtbubl_sndcomm;

  logic       clk24 = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       main_cs = 1'b0, main_wrn = 1'b1;
  logic [1:0] main_addr = 2'd0;
  logic [7:0] main_din = 8'd0;
  logic [7:0] main_dout;
  logic       snd_cs = 1'b0, snd_wrn = 1'b1, snd_addr = 1'b0;
  logic [7:0] snd_din = 8'd0;
  logic [7:0] snd_dout;
  logic       snd_nmi_n, snd_rst;

  int checks = 0;
  int failures = 0;

  jtbubl_sndcomm #(.RST_LEN(16)) dut (
    .clk24(clk24), .rst_n(rst_n), .cen(cen),
    .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr),
    .main_din(main_din), .main_dout(main_dout),
    .snd_cs(snd_cs), .snd_wrn(snd_wrn), .snd_addr(snd_addr),
    .snd_din(snd_din), .snd_dout(snd_dout),
    .snd_nmi_n(snd_nmi_n), .snd_rst(snd_rst)
  );

  always #5 clk24 = ~clk24;

  task automatic tick();
    @(posedge clk24); #1;
  endtask

  task automatic cen_tick();
    cen = 1'b1; tick(); cen = 1'b0;
  endtask

  task automatic main_write(input logic [1:0] a, input logic [7:0] d, input int hold);
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = a; main_din = d;
    repeat (hold) tick();
    main_cs = 1'b0; main_wrn = 1'b1;
    tick();
  endtask

  task automatic main_read(input logic [1:0] a, output logic [7:0] d);
    main_cs = 1'b1; main_wrn = 1'b1; main_addr = a;
    tick();
    d = main_dout;
    main_cs = 1'b0;
    tick();
  endtask

  task automatic snd_write(input logic a, input logic [7:0] d);
    snd_cs = 1'b1; snd_wrn = 1'b0; snd_addr = a; snd_din = d;
    repeat (2) tick();
    snd_cs = 1'b0; snd_wrn = 1'b1;
    tick();
  endtask

  task automatic snd_read(input logic a, output logic [7:0] d);
    snd_cs = 1'b1; snd_wrn = 1'b1; snd_addr = a;
    tick();
    d = snd_dout;
    snd_cs = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) tick();
    checks++; if (snd_rst !== 1'b1) begin failures++; $display("FAIL rst_snd_rst got %b exp 1", snd_rst); end
    checks++; if (snd_nmi_n !== 1'b1) begin failures++; $display("FAIL rst_nmi_n got %b exp 1", snd_nmi_n); end
    checks++; if (main_dout !== 8'hFF) begin failures++; $display("FAIL rst_main_idle got %h exp ff", main_dout); end
    checks++; if (snd_dout !== 8'hFF) begin failures++; $display("FAIL rst_snd_idle got %h exp ff", snd_dout); end
    rst_n = 1'b1;
    repeat (2) tick();
    main_read(2'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_main_status got %h exp 00", d); end
    main_read(2'd2, d);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL main_addr2 got %h exp ff", d); end
    snd_read(1'b0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_cmd got %h exp 00", d); end
  endtask

  task automatic test_release();
    main_write(2'd3, 8'h00, 2);
    for (int i = 1; i <= 15; i++) cen_tick();
    checks++; if (snd_rst !== 1'b1) begin failures++; $display("FAIL release_15 got %b exp 1", snd_rst); end
    cen_tick();
    checks++; if (snd_rst !== 1'b1) begin failures++; $display("FAIL release_16 got %b exp 1", snd_rst); end
    tick();
    checks++; if (snd_rst !== 1'b0) begin failures++; $display("FAIL release_done got %b exp 0", snd_rst); end
    repeat (4) cen_tick();
    checks++; if (snd_rst !== 1'b0) begin failures++; $display("FAIL release_stay got %b exp 0", snd_rst); end
    checks++; if (snd_nmi_n !== 1'b1) begin failures++; $display("FAIL release_nmi got %b exp 1", snd_nmi_n); end
  endtask

  task automatic test_nmi();
    logic [7:0] d;
    snd_write(1'b1, 8'h02);
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 2'd0; main_din = 8'h5A;
    tick();
    checks++; if (snd_nmi_n !== 1'b1) begin failures++; $display("FAIL nmi_early got %b exp 1", snd_nmi_n); end
    tick();
    checks++; if (snd_nmi_n !== 1'b0) begin failures++; $display("FAIL nmi_assert got %b exp 0", snd_nmi_n); end
    repeat (6) tick();
    main_cs = 1'b0; main_wrn = 1'b1;
    tick();
    main_read(2'd1, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL nmi_single_write got %h exp 01", d); end
    snd_read(1'b0, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL nmi_cmd got %h exp 5a", d); end
    checks++; if (snd_nmi_n !== 1'b0) begin failures++; $display("FAIL nmi_hold got %b exp 0", snd_nmi_n); end
    tick();
    checks++; if (snd_nmi_n !== 1'b1) begin failures++; $display("FAIL nmi_release got %b exp 1", snd_nmi_n); end
    main_read(2'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL nmi_status_clr got %h exp 00", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    main_write(2'd0, 8'h11, 2);
    main_write(2'd0, 8'h22, 2);
    main_read(2'd1, d);
    checks++; if (d !== 8'h05) begin failures++; $display("FAIL ovr_status got %h exp 05", d); end
    main_read(2'd1, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL ovr_cleared got %h exp 01", d); end
    snd_read(1'b0, d);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL ovr_cmd got %h exp 22", d); end
    main_read(2'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL ovr_final got %h exp 00", d); end
  endtask

  task automatic test_reply();
    logic [7:0] d;
    snd_write(1'b0, 8'hC3);
    main_read(2'd1, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL reply_status got %h exp 02", d); end
    snd_read(1'b1, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL reply_snd_status got %h exp 02", d); end
    main_read(2'd0, d);
    checks++; if (d !== 8'hC3) begin failures++; $display("FAIL reply_data got %h exp c3", d); end
    main_read(2'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reply_clr got %h exp 00", d); end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    main_write(2'd0, 8'h33, 2);
    snd_cs = 1'b1; snd_wrn = 1'b1; snd_addr = 1'b0;
    tick();
    checks++; if (snd_dout !== 8'h33) begin failures++; $display("FAIL coll_first got %h exp 33", snd_dout); end
    snd_cs = 1'b0;
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 2'd0; main_din = 8'h44;
    tick();
    main_cs = 1'b0; main_wrn = 1'b1;
    tick();
    snd_read(1'b1, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL coll_pend got %h exp 01", d); end
    main_read(2'd1, d);
    checks++; if (d !== 8'h05) begin failures++; $display("FAIL coll_main_status got %h exp 05", d); end
    snd_read(1'b0, d);
    checks++; if (d !== 8'h44) begin failures++; $display("FAIL coll_cmd got %h exp 44", d); end
    main_read(2'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL coll_final got %h exp 00", d); end
    tick();
  endtask

  task automatic test_nmi_disable();
    logic [7:0] d;
    snd_write(1'b1, 8'h03);
    main_write(2'd0, 8'h66, 1);
    repeat (2) tick();
    checks++; if (snd_nmi_n !== 1'b1) begin failures++; $display("FAIL dis_wins got %b exp 1", snd_nmi_n); end
    snd_write(1'b1, 8'h02);
    checks++; if (snd_nmi_n !== 1'b0) begin failures++; $display("FAIL reenable got %b exp 0", snd_nmi_n); end
    snd_read(1'b0, d);
    checks++; if (d !== 8'h66) begin failures++; $display("FAIL dis_cmd got %h exp 66", d); end
    tick();
    checks++; if (snd_nmi_n !== 1'b1) begin failures++; $display("FAIL dis_release got %b exp 1", snd_nmi_n); end
  endtask

  task automatic test_reset_restart();
    logic [7:0] d;
    main_write(2'd3, 8'h01, 1);
    checks++; if (snd_rst !== 1'b1) begin failures++; $display("FAIL rr_assert got %b exp 1", snd_rst); end
    main_write(2'd3, 8'h00, 1);
    repeat (8) cen_tick();
    main_write(2'd3, 8'h01, 1);
    main_write(2'd3, 8'h00, 1);
    main_write(2'd0, 8'h77, 1);
    snd_write(1'b1, 8'h02);
    snd_write(1'b0, 8'h99);
    for (int i = 1; i <= 15; i++) cen_tick();
    checks++; if (snd_rst !== 1'b1) begin failures++; $display("FAIL rr_15 got %b exp 1", snd_rst); end
    cen_tick();
    checks++; if (snd_rst !== 1'b1) begin failures++; $display("FAIL rr_16 got %b exp 1", snd_rst); end
    tick();
    checks++; if (snd_rst !== 1'b0) begin failures++; $display("FAIL rr_done got %b exp 0", snd_rst); end
    repeat (3) tick();
    checks++; if (snd_nmi_n !== 1'b1) begin failures++; $display("FAIL rr_nmi_en got %b exp 1", snd_nmi_n); end
    main_read(2'd1, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL rr_status got %h exp 01", d); end
    snd_read(1'b0, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL rr_cmd got %h exp 77", d); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_nmi();
    test_overrun();
    test_reply();
    test_collision();
    test_nmi_disable();
    test_reset_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
